// File: rtl/ssd_scanner_pkg.sv
// Shared constants, phase encoding and glyph lookup for the seven-segment scanner.
// All segment values are active-low: bit 0 = a ... bit 6 = g.
package ssd_scanner_pkg;

  localparam logic [7:0] CHAR_BLANK = 8'h10;
  localparam logic [7:0] CHAR_DASH  = 8'h11;
  localparam logic [7:0] CHAR_UNDER = 8'h12;

  localparam logic [3:0] ANODES_OFF = 4'hF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_UNDER = 7'h77;

  // Slot phase: anodes are held off during GUARD to stop ghosting between digits.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_char_decoder.sv
// Combinational byte-to-segment decode: character code (mode=1) or raw segment bits (mode=0).
// Outputs are active-low, ready to drive the cathodes.
module ssd_char_decoder
  import ssd_scanner_pkg::*;
(
  input  logic [7:0] code,
  input  logic       char_mode,
  output logic [6:0] seg,
  output logic       dp
);

  always_comb begin
    seg = SEG_OFF;
    dp  = 1'b1;
    if (char_mode) begin
      // Bit 7 of a character code requests the decimal point.
      dp = ~code[7];
      if (code[6:4] == 3'b000) begin
        seg = hex_glyph(code[3:0]);
      end else if ({1'b0, code[6:0]} == CHAR_DASH) begin
        seg = GLYPH_DASH;
      end else if ({1'b0, code[6:0]} == CHAR_UNDER) begin
        seg = GLYPH_UNDER;
      end else begin
        seg = SEG_OFF;
      end
    end else begin
      seg = code[6:0];
      dp  = code[7];
    end
  end

endmodule

// File: rtl/ssd_scanner.sv
// Four-digit common-anode scanner: latches the display image once per frame and
// multiplexes it across the digits with an all-off guard window at the start of each slot.
module ssd_scanner
  import ssd_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ssd_bits,
  input  logic        ssd_char_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_CYCLES);
  localparam phase_t PH_RESET = (GUARD_CYCLES == 0) ? PH_DRIVE : PH_GUARD;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       dig, dig_d;
  logic [31:0]      shadow, shadow_d;
  logic             shadow_mode, shadow_mode_d;
  logic             latch;

  phase_t           phase, phase_d;

  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic [7:0]       cur_byte;
  logic [6:0]       dec_seg;
  logic             dec_dp;

  // Frame boundary: the only point at which the visible image may change.
  assign latch = (cnt == '0) && (dig == 2'd0);

  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    dig_d = dig;
    if (cnt == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig + 2'd1;
    end
  end

  // A byte decoded in the latch cycle uses the image being captured, so a
  // zero-length guard still shows the new frame from its first cycle.
  always_comb begin
    shadow_d      = shadow;
    shadow_mode_d = shadow_mode;
    if (latch) begin
      shadow_d      = ssd_bits;
      shadow_mode_d = ssd_char_mode;
    end
  end

  assign cur_byte = shadow_d[{dig, 3'b000} +: 8];

  ssd_char_decoder u_decoder (
    .code      (cur_byte),
    .char_mode (shadow_mode_d),
    .seg       (dec_seg),
    .dp        (dec_dp)
  );

  // Phase FSM: the state register tracks the phase of the current cnt value.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_RESET;
    end else begin
      phase <= phase_d;
    end
  end

  always_comb begin
    phase_d = PH_DRIVE;
    an_d    = ANODES_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if ((GUARD_CYCLES != 0) && (cnt_d < GUARD_CNT)) begin
      phase_d = PH_GUARD;
    end
    case (phase)
      PH_DRIVE: begin
        an_d  = ~(4'b0001 << dig);
        seg_d = dec_seg;
        dp_d  = dec_dp;
      end
      default: begin
        an_d  = ANODES_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dig         <= 2'd0;
      shadow      <= 32'hFFFF_FFFF;
      shadow_mode <= 1'b0;
      frame_tick  <= 1'b0;
      an          <= ANODES_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      cnt         <= cnt_d;
      dig         <= dig_d;
      shadow      <= shadow_d;
      shadow_mode <= shadow_mode_d;
      frame_tick  <= latch;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

endmodule

// File: tb/tb_ssd_scanner.sv
// Bench for ssd_scanner: directed scenarios plus random images, checked every cycle
// against a cycle-position model of the scan (frame position -> digit, phase, glyph).
module tb_ssd_scanner;

  localparam int S     = 8;
  localparam int G     = 2;
  localparam int FRAME = 4 * S;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ssd_bits;
  logic        ssd_char_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Model state: cycles elapsed since reset release and the image of the current frame.
  int          pos = 0;
  logic [31:0] m_img = 32'hFFFF_FFFF;
  logic        m_mode = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scanner #(.SLOT_CYCLES(S), .GUARD_CYCLES(G)) dut (
    .clk           (clk),
    .rst           (rst),
    .ssd_bits      (ssd_bits),
    .ssd_char_mode (ssd_char_mode),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] decode(input logic [7:0] b, input logic md);
    logic [6:0] s;
    logic       d;
    int         code;
    if (!md) return b[7:0];
    code = int'(b[6:0]);
    d = ~b[7];
    if (code < 16)        s = hex_tab[code];
    else if (code == 17)  s = 7'h3F;
    else if (code == 18)  s = 7'h77;
    else                  s = 7'h7F;
    return {d, s};
  endfunction

  // Advance one clock: predict from the inputs presented before the edge, then compare.
  task automatic tick(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    logic [7:0] dd;
    int         c, d;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      pos = 0; m_img = 32'hFFFF_FFFF; m_mode = 1'b0;
    end else begin
      e_ft = ((pos % FRAME) == 0);
      if (e_ft) begin
        m_img  = ssd_bits;
        m_mode = ssd_char_mode;
      end
      c = pos % S;
      d = (pos / S) % 4;
      if (c < G) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = 4'hF;
        e_an[d] = 1'b0;
        dd = decode(m_img[d*8 +: 8], m_mode);
        e_seg = dd[6:0];
        e_dp  = dd[7];
      end
      pos++;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (an === e_an) else begin
      errors++;
      $error("FAIL %s an observed %h expected %h (pos %0d)", tag, an, e_an, pos);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("FAIL %s seg observed %h expected %h (pos %0d)", tag, seg, e_seg, pos);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++;
      $error("FAIL %s dp observed %b expected %b (pos %0d)", tag, dp, e_dp, pos);
    end
    checks++;
    assert (frame_tick === e_ft) else begin
      errors++;
      $error("FAIL %s frame_tick observed %b expected %b (pos %0d)", tag, frame_tick, e_ft, pos);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Step until the model's next pre-edge frame position equals target (at most one frame).
  task automatic run_to(input string tag, input int target);
    for (int i = 0; i < FRAME && (pos % FRAME) != target; i++) tick(tag);
  endtask

  initial begin
    rst = 1'b1;
    ssd_bits = 32'h0102_0A0F;
    ssd_char_mode = 1'b1;
    run("reset", 3);

    rst = 1'b0;
    run("hex_image", 2 * FRAME + 3);

    ssd_bits = 32'h7F00_FF80;
    ssd_char_mode = 1'b0;
    run_to("bits_sync", 0);
    run("bits_mode", FRAME);

    ssd_bits = 32'h3C11_8812;
    ssd_char_mode = 1'b1;
    run_to("char_sync", 0);
    run("char_specials", FRAME);

    // Image change in the middle of the digit-2 slot must not reach digits 2/3 until next frame.
    ssd_bits = 32'h0102_0A0F;
    run_to("tear_sync", 0);
    run_to("tear_pre", 2 * S + 3);
    ssd_bits = 32'h0000_0000;
    run("tear_free", FRAME + 8);

    ssd_bits = 32'h0102_0A0F;
    run_to("midrst_sync", 2 * S + G + 2);
    rst = 1'b1;
    run("mid_reset", 1);
    rst = 1'b0;
    run("after_reset", FRAME + 10);

    // Latch-cycle capture: change the image exactly on the frame boundary cycle.
    run_to("latch_sync", 0);
    ssd_bits = 32'h1112_0880;
    run("latch_edge", FRAME);

    for (int k = 0; k < 24; k++) begin
      ssd_bits = $urandom();
      ssd_char_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < 4; b++) ssd_bits[b*8 +: 8] = 8'($urandom_range(0, 8'h1F)) | (8'($urandom_range(0, 1)) << 7);
      end
      rst = ($urandom_range(0, 9) == 0);
      tick("random_rst");
      rst = 1'b0;
      run("random", $urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scanner.md
Name: ssd_scanner

Overview:
- Downstream consumer of the IO port driver's seven-segment outputs.
- Takes the 32-bit display image (`ssd_bits`, one byte per digit) and the `ssd_char_mode` flag, and time-multiplexes them onto a 4-digit common-anode display.
- Each byte is either a character code (decoded to a glyph) or a raw segment pattern.
- Latches the image once per frame for tear-free updates, and inserts an all-off guard window between digits to suppress ghosting.

Parameters:
- SLOT_CYCLES, 100000: clock cycles per digit slot (100 MHz gives a 250 Hz frame). Must be ≥2.
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off. Range 0 ≤ GUARD_CYCLES < SLOT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ssd_bits  in  32  display image; byte k = digit k, digit 0 = rightmost
- ssd_char_mode  in  1  1 = bytes are char codes, 0 = bytes are raw segment bits
- an  out  4  anode enables, active-low, an[k] = digit k
- seg  out  7  cathodes, active-low, seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when a new frame's image is latched

Behaviour:

Interface (already decided):
- One clock, `clk`.
- Reset `rst` is synchronous and active-high.

Reset values and state:
- an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
- slot counter `cnt`=0, digit index `dig`=0.
- shadow image=32'hFFFFFFFF, shadow mode=0.

Counters:
- `cnt` counts 0..SLOT_CYCLES-1 and wraps.
- On the wrap, `dig` increments 0→1→2→3→0.

Shadow latch:
- Condition: any cycle with `cnt`==0 and `dig`==0, including the first cycle after reset release.
- Action: shadow image ← ssd_bits and shadow mode ← ssd_char_mode, both loaded in the same cycle.
- frame_tick is registered: it is 1 in the cycle after that condition.
- Input changes at any other time are invisible until the next frame boundary.
- Frame period is 4·SLOT_CYCLES.

Per-slot phases (two-state FSM, GUARD then DRIVE):
- GUARD: `cnt` < GUARD_CYCLES. Next an=4'hF, seg=7'h7F, dp=1.
- DRIVE: `cnt` ≥ GUARD_CYCLES. Next an = one-cold on `dig`; seg and dp come from the decode of shadow byte `dig`.
- With GUARD_CYCLES=0, the FSM stays in DRIVE.

Output timing:
- an, seg and dp are registered.
- They reflect the counter state of the previous cycle, i.e. one cycle of latency.

Decode, char mode (shadow mode=1):
- Code bits[6:0] select the glyph; bit 7=1 lights dp.
- 0x00–0x0F: hex glyphs. Examples: 0→7'h40, 1→7'h79, 2→7'h24, 8→7'h00, A→7'h08, F→7'h0E.
- 0x10: blank.
- 0x11: '-' (7'h3F).
- 0x12: '_' (7'h77).
- All other codes: blank (7'h7F).

Decode, bits mode (shadow mode=0):
- seg = byte[6:0] and dp = byte[7], passed through unchanged (already active-low).

Boundary conditions:
- rst mid-frame: on the next edge, outputs and state take reset values; the frame restarts at digit 0 with a fresh shadow latch.
- A change to ssd_bits coinciding with the latch cycle is captured.

Decomposition:
- Shared header `parameters.vh`:
  - char-code constants: CHAR_BLANK=0x10, CHAR_DASH=0x11, CHAR_UNDER=0x12;
  - glyph constants;
  - ANODES_OFF, SEG_OFF.
- Sub-module `ssd_char_decoder`: combinational, inputs 8-bit byte and mode; outputs seg[6:0] and dp. Instantiated once and fed by a shadow-byte mux on `dig`.
- Counters, FSM, shadow latch and output registers live in the top module.

Test Plan:
All scenarios use SLOT_CYCLES=8, GUARD_CYCLES=2.
1. Reset: hold rst for 3 cycles with ssd_bits=0x01020A0F → an=4'hF, seg=7'h7F, dp=1, frame_tick=0 throughout.
2. Hex image: release rst with ssd_bits=0x01020A0F, mode=1.
   - frame_tick=1 in cycle 1.
   - Digit 0 slot: an=4'hF for 2 cycles, then an=4'b1110, seg=7'h0E, for 6 cycles.
   - Following slots: digit 1 seg=7'h08, digit 2 seg=7'h24, digit 3 seg=7'h79.
   - frame_tick repeats every 32 cycles.
3. Bits mode: ssd_bits=0x7F00FF80, mode=0.
   - digit 0: seg=7'h00, dp=1.
   - digit 1: seg=7'h7F, dp=1.
   - digit 2: seg=7'h00, dp=0.
   - digit 3: seg=7'h7F, dp=0.
4. Char specials: ssd_bits=0x3C118812, mode=1.
   - digit 0 seg=7'h77.
   - digit 1 seg=7'h00, dp=0.
   - digit 2 seg=7'h3F.
   - digit 3 blank, 7'h7F.
5. Tear-free update: change ssd_bits from 0x01020A0F to 0x00000000 during the digit-2 slot → digits 2 and 3 still show 2 and 1 (7'h24, 7'h79); from the next frame all digits show 7'h40.
6. Reset mid-frame: assert rst for 1 cycle during the digit-2 DRIVE phase → next cycle an=4'hF; the scan resumes at digit 0 with the re-latched image, and frame_tick is seen again 1 cycle after release.
